// File: rtl/cnn_pkg.sv
// Shared CNN datapath package: lane geometry, ReLU sequencer states and
// a lane-sign helper used by the optional clamp statistics (RELU_SEQ_STATS_EN).
package cnn_pkg;

  localparam int LANE_W = 8;
  localparam int LANES  = 4;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    DONE
  } relu_seq_state_t;

  // Number of lanes in a packed word whose sign bit is set (0..LANES).
  function automatic logic [2:0] count_neg(input logic [WORD_W-1:0] word);
    logic [2:0] cnt;
    cnt = '0;
    for (int k = 0; k < LANES; k++) begin
      cnt = cnt + {2'b00, word[k*LANE_W + LANE_W-1]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/relu_seq_ctrl_if.sv
// Handshake and buffer-port bundle of the ReLU sequencer.
// master = sequencer side, slave = layer controller / feature buffers.
// neg_cnt exists only when RELU_SEQ_STATS_EN is defined.
interface relu_seq_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] src_base;
  logic [ADDR_W-1:0] dst_base;
  logic [ADDR_W-1:0] len;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              wr_ready;
`ifdef RELU_SEQ_STATS_EN
  logic [ADDR_W+1:0] neg_cnt;

  modport master (
    input  start, abort, src_base, dst_base, len, rd_data, wr_ready,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data, neg_cnt
  );
  modport slave (
    output start, abort, src_base, dst_base, len, rd_data, wr_ready,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data, neg_cnt
  );
`else
  modport master (
    input  start, abort, src_base, dst_base, len, rd_data, wr_ready,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
  modport slave (
    output start, abort, src_base, dst_base, len, rd_data, wr_ready,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
`endif
endinterface

// File: rtl/relu_lane4.sv
// Purely combinational 4-lane int8 ReLU: a lane with its sign bit set
// becomes zero, any other lane passes through unchanged.
module relu_lane4
  import cnn_pkg::*;
(
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout
);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign dout[k*LANE_W +: LANE_W] =
      din[k*LANE_W + LANE_W-1] ? '0 : din[k*LANE_W +: LANE_W];
  end

endmodule

// File: rtl/relu_seq_ctrl.sv
// ReLU pass sequencer: reads len words from src_base, clamps each through
// relu_lane4 and writes them to dst_base, one word in flight at a time.
// Optional clamped-lane statistics are built when RELU_SEQ_STATS_EN is defined.
module relu_seq_ctrl
  import cnn_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  relu_seq_ctrl_if.master bus
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  relu_seq_state_t   state;
  logic [ADDR_W-1:0] src_q, dst_q, len_q, idx;
  logic [WORD_W-1:0] hold;
  logic [WORD_W-1:0] relu_data;
  logic              busy_q, done_q, rd_en_q, wr_en_q;
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;

  relu_lane4 u_lane (
    .din  (bus.rd_data),
    .dout (relu_data)
  );

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = hold;

  // Pass FSM with every output registered alongside the state transition.
  // NOTE: all state and output registers use non-blocking assignments so every
  // branch sees the pre-edge values of idx/len_q regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      idx       <= '0;
      hold      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
    end else if (bus.abort && state != IDLE) begin
      // Cancel: drop back to IDLE silently; idx keeps its value until next start.
      state   <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            src_q  <= bus.src_base;
            dst_q  <= bus.dst_base;
            len_q  <= bus.len;
            idx    <= '0;
            busy_q <= 1'b1;
            if (bus.len != '0) begin
              state     <= RD;
              rd_en_q   <= 1'b1;
              rd_addr_q <= bus.src_base;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        RD: begin
          rd_en_q <= 1'b0;
          state   <= CAP;
        end
        CAP: begin
          hold      <= relu_data;
          wr_en_q   <= 1'b1;
          wr_addr_q <= dst_q + idx;
          state     <= WR;
        end
        WR: begin
          if (bus.wr_ready) begin
            wr_en_q <= 1'b0;
            if (idx == len_q - ONE) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              idx       <= idx + ONE;
              rd_en_q   <= 1'b1;
              rd_addr_q <= src_q + idx + ONE;
              state     <= RD;
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RELU_SEQ_STATS_EN
  localparam int CNT_W = ADDR_W + 2;

  logic [CNT_W-1:0] neg_cnt_q;
  logic [CNT_W:0]   neg_sum;

  assign neg_sum     = {1'b0, neg_cnt_q} + (CNT_W+1)'(count_neg(bus.rd_data));
  assign bus.neg_cnt = neg_cnt_q;

  // Saturating count of clamped lanes, cleared on accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_cnt_q <= '0;
    end else if (state == IDLE && bus.start && !bus.abort) begin
      neg_cnt_q <= '0;
    end else if (state == CAP && !bus.abort) begin
      neg_cnt_q <= neg_sum[CNT_W] ? '1 : neg_sum[CNT_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_relu_seq_ctrl.sv
// Directed self-checking bench for relu_seq_ctrl with a scratchpad read model
// and a logging write sink. Statistics checks apply when RELU_SEQ_STATS_EN is defined.
module tb_relu_seq_ctrl;

  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  relu_seq_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  relu_seq_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [256];

  // Source buffer: data valid one cycle after rd_en.
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

  int checks = 0;
  int failures = 0;

  int cyc = 0, busy_cnt = 0, done_cnt = 0, first_busy = -1, done_cyc = -1;
  logic [7:0]  rd_log[$];
  logic [7:0]  wa_log[$];
  logic [31:0] wd_log[$];

  // Observe reads, accepted writes, busy and done at each rising edge.
  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      if (bus.rd_en) rd_log.push_back(bus.rd_addr);
      if (bus.wr_en && bus.wr_ready) begin
        wa_log.push_back(bus.wr_addr);
        wd_log.push_back(bus.wr_data);
      end
      if (bus.busy) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = cyc;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    rd_log.delete();
    wa_log.delete();
    wd_log.delete();
    busy_cnt   = 0;
    first_busy = -1;
    done_cyc   = -1;
  endtask

  task automatic start_pass(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
    @(negedge clk);
    bus.src_base = s;
    bus.dst_base = d;
    bus.len      = l;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.src_base = 8'hAA;
    bus.dst_base = 8'hBB;
    bus.len      = 8'h55;
  endtask

  task automatic wait_done(input string tag);
    int n0;
    n0 = done_cnt;
    for (int i = 0; i < 200 && done_cnt == n0; i++) @(negedge clk);
    check({tag, "_done_seen"}, done_cnt - n0, 1);
    @(negedge clk);
    check({tag, "_busy_low"}, bus.busy, 1'b0);
  endtask

  task automatic check_log(input string tag, input int n,
                           input logic [7:0] er[4], input logic [7:0] ew[4],
                           input logic [31:0] ed[4]);
    check({tag, "_rd_count"}, rd_log.size(), n);
    check({tag, "_wr_count"}, wa_log.size(), n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_rd_addr"}, i < rd_log.size() ? rd_log[i] : 8'hxx, er[i]);
      check({tag, "_wr_addr"}, i < wa_log.size() ? wa_log[i] : 8'hxx, ew[i]);
      check({tag, "_wr_data"}, i < wd_log.size() ? wd_log[i] : 32'hxxxx_xxxx, ed[i]);
    end
  endtask

  initial begin
    logic [7:0]  er[4];
    logic [7:0]  ew[4];
    logic [31:0] ed[4];
    int          n0;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.wr_ready = 1'b1;
    bus.src_base = '0; bus.dst_base = '0; bus.len = '0;
    rst_n = 1'b0;

    // Reset state
    #12;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_rd_en", bus.rd_en, 1'b0);
    check("rst_wr_en", bus.wr_en, 1'b0);
    check("rst_rd_addr", bus.rd_addr, 8'h00);
    check("rst_wr_addr", bus.wr_addr, 8'h00);
    check("rst_wr_data", bus.wr_data, 32'h0);
`ifdef RELU_SEQ_STATS_EN
    check("rst_neg_cnt", bus.neg_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Single word
    mem[8'h10] = 32'h807F_FF01;
    clear_log();
    start_pass(8'h10, 8'h20, 8'd1);
    check("t1_busy_rise", bus.busy, 1'b1);
    wait_done("t1");
    er = '{8'h10, 0, 0, 0}; ew = '{8'h20, 0, 0, 0}; ed = '{32'h007F_0001, 0, 0, 0};
    check_log("t1", 1, er, ew, ed);
    check("t1_busy_cycles", busy_cnt, 4);
    check("t1_done_offset", done_cyc - first_busy, 3);
`ifdef RELU_SEQ_STATS_EN
    check("t1_neg_cnt", bus.neg_cnt, 2);
`endif

    // Burst with address wrap
    mem[8'hFE] = 32'h0102_0304;
    mem[8'hFF] = 32'h8081_8283;
    mem[8'h00] = 32'h7F00_FF10;
    clear_log();
    start_pass(8'hFE, 8'hFF, 8'd3);
    wait_done("t2");
    er = '{8'hFE, 8'hFF, 8'h00, 0}; ew = '{8'hFF, 8'h00, 8'h01, 0};
    ed = '{32'h0102_0304, 32'h0000_0000, 32'h7F00_0010, 0};
    check_log("t2", 3, er, ew, ed);
    check("t2_busy_cycles", busy_cnt, 10);
`ifdef RELU_SEQ_STATS_EN
    check("t2_neg_cnt", bus.neg_cnt, 5);
`endif

    // Back-pressure on the first write
    mem[8'h30] = 32'h1122_3344;
    mem[8'h31] = 32'hF000_0001;
    clear_log();
    bus.wr_ready = 1'b0;
    start_pass(8'h30, 8'h40, 8'd2);
    for (int i = 0; i < 20 && !bus.wr_en; i++) @(negedge clk);
    check("t3_wr_seen", bus.wr_en, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("t3_stall_wr_en", bus.wr_en, 1'b1);
      check("t3_stall_wr_addr", bus.wr_addr, 8'h40);
      check("t3_stall_wr_data", bus.wr_data, 32'h1122_3344);
      check("t3_stall_rd_en", bus.rd_en, 1'b0);
      @(negedge clk);
    end
    bus.wr_ready = 1'b1;
    wait_done("t3");
    er = '{8'h30, 8'h31, 0, 0}; ew = '{8'h40, 8'h41, 0, 0};
    ed = '{32'h1122_3344, 32'h0000_0001, 0, 0};
    check_log("t3", 2, er, ew, ed);
    check("t3_busy_cycles", busy_cnt, 12);
    check("t3_done_offset", done_cyc - first_busy, 11);
`ifdef RELU_SEQ_STATS_EN
    check("t3_neg_cnt", bus.neg_cnt, 1);
`endif

    // Empty pass
    clear_log();
    start_pass(8'h05, 8'h06, 8'd0);
    check("t4_done_pulse", bus.done, 1'b1);
    check("t4_busy", bus.busy, 1'b1);
    @(negedge clk);
    check("t4_done_low", bus.done, 1'b0);
    check("t4_busy_low", bus.busy, 1'b0);
    check("t4_rd_count", rd_log.size(), 0);
    check("t4_wr_count", wa_log.size(), 0);
    check("t4_busy_cycles", busy_cnt, 1);
`ifdef RELU_SEQ_STATS_EN
    check("t4_neg_cnt", bus.neg_cnt, 0);
`endif

    // Start pulsed mid-pass is ignored
    mem[8'h60] = 32'h01FF_7F80;
    mem[8'h61] = 32'h0A0B_0C0D;
    clear_log();
    start_pass(8'h60, 8'h70, 8'd2);
    @(negedge clk);
    bus.src_base = 8'h90; bus.dst_base = 8'h91; bus.len = 8'd5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("t4b");
    er = '{8'h60, 8'h61, 0, 0}; ew = '{8'h70, 8'h71, 0, 0};
    ed = '{32'h0100_7F00, 32'h0A0B_0C0D, 0, 0};
    check_log("t4b", 2, er, ew, ed);
    check("t4b_busy_cycles", busy_cnt, 7);

    // Abort in WR of word 2 of 4
    mem[8'h50] = 32'h0000_0001; mem[8'h51] = 32'h0000_0002;
    mem[8'h52] = 32'h0000_0003; mem[8'h53] = 32'h0000_0004;
    clear_log();
    n0 = done_cnt;
    start_pass(8'h50, 8'h58, 8'd4);
    for (int i = 0; i < 100 && !(wa_log.size() == 1 && bus.wr_en); i++) @(negedge clk);
    check("t5_in_wr2", bus.wr_addr, 8'h59);
    bus.abort = 1'b1; bus.wr_ready = 1'b0;
    @(negedge clk);
    bus.abort = 1'b0; bus.wr_ready = 1'b1;
    check("t5_wr_en_low", bus.wr_en, 1'b0);
    check("t5_rd_en_low", bus.rd_en, 1'b0);
    check("t5_busy_low", bus.busy, 1'b0);
    repeat (4) @(negedge clk);
    check("t5_no_done", done_cnt - n0, 0);
    check("t5_wr_count", wa_log.size(), 1);

    // Abort and start together in IDLE: start dropped
    @(negedge clk);
    bus.len = 8'd1; bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    check("t5_abort_start_busy", bus.busy, 1'b0);

    // Normal pass after abort
    mem[8'h75] = 32'h7FFF_FFFF;
    clear_log();
    start_pass(8'h75, 8'h76, 8'd1);
    wait_done("t5b");
    er = '{8'h75, 0, 0, 0}; ew = '{8'h76, 0, 0, 0}; ed = '{32'h7F00_0000, 0, 0, 0};
    check_log("t5b", 1, er, ew, ed);

    // Asynchronous reset in CAP
    mem[8'h33] = 32'h1234_5678;
    clear_log();
    n0 = done_cnt;
    start_pass(8'h33, 8'h44, 8'd1);
    check("t6_rd_en_in_rd", bus.rd_en, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy", bus.busy, 1'b0);
    check("t6_done", bus.done, 1'b0);
    check("t6_rd_en", bus.rd_en, 1'b0);
    check("t6_wr_en", bus.wr_en, 1'b0);
    check("t6_rd_addr", bus.rd_addr, 8'h00);
    check("t6_wr_addr", bus.wr_addr, 8'h00);
    check("t6_wr_data", bus.wr_data, 32'h0);
`ifdef RELU_SEQ_STATS_EN
    check("t6_neg_cnt", bus.neg_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_idle_busy", bus.busy, 1'b0);
    check("t6_no_done", done_cnt - n0, 0);
    check("t6_no_write", wa_log.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/relu_seq_ctrl.md
# relu_seq_ctrl

Sequencer that streams a block of packed int8 feature-map words from a scratchpad read port, through the 4-lane ReLU datapath, and into a destination write port. It sits between the layer controller (start/done) and the on-chip feature buffers and owns all addressing and handshaking for a ReLU pass. One word is in flight at a time. Write back-pressure is honoured without data loss.

## Interface
- ADDR_W, 8, word address width of source and destination buffers; also the width of the length count
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a pass; sampled only in IDLE
- abort  in  1  synchronous cancel; wins over every other event except reset
- src_base  in  ADDR_W  first source word address, latched on accepted start
- dst_base  in  ADDR_W  first destination word address, latched on accepted start
- len  in  ADDR_W  number of words to process, latched on accepted start; 0 = empty pass
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on pass completion
- rd_en  out  1  source read strobe
- rd_addr  out  ADDR_W  source read address
- rd_data  in  32  source data, valid exactly one cycle after rd_en
- wr_en  out  1  destination write request; held until accepted
- wr_addr  out  ADDR_W  destination address
- wr_data  out  32  ReLU result
- wr_ready  in  1  write accepted when wr_en && wr_ready
- neg_cnt  out  ADDR_W+2  clamped-lane count; present only with RELU_SEQ_STATS_EN

## Operation
- ReLU rule: lane k = bits 8k+7:8k, signed two's complement. Bit 7 of the lane = 1 -> lane becomes 8'h00. Otherwise the lane passes unchanged. Lanes are independent.
- FSM states:
  - IDLE: start && len!=0 -> RD. start && len==0 -> DONE.
  - RD: rd_en=1, rd_addr=src_base_q+idx. Next state is CAP.
  - CAP: hold <= relu(rd_data). Next state is WR.
  - WR: wr_en=1, wr_addr=dst_base_q+idx, wr_data=hold. On wr_ready:
    - idx==len_q-1 -> DONE
    - otherwise idx++ and -> RD
    - no wr_ready -> stay in WR with outputs stable.
  - DONE: done=1 for one cycle. Next state is IDLE.
- idx is an ADDR_W counter, cleared on accepted start.
- Address sums wrap modulo 2^ADDR_W, e.g. base 8'hFE with idx 3 gives 8'h01.
- start outside IDLE is ignored. Base and length inputs may change freely after acceptance.
- abort in any non-IDLE state:
  - next state is IDLE
  - wr_en and rd_en are 0 from the following cycle
  - no done pulse
  - idx is not cleared until the next start
- abort in IDLE has no effect. abort and start in the same IDLE cycle: abort wins, the start is dropped.

## Timing
- Reset values:
  - state IDLE
  - busy=0, done=0, rd_en=0, wr_en=0
  - rd_addr=0, wr_addr=0, wr_data=0
  - idx=0, hold=0, neg_cnt=0
- Reset asserted mid-pass forces these values immediately. No done pulse is produced.
- All outputs are registered or decoded from state and registers. No combinational path from any input to any output.
- Per word with wr_ready held high: 3 cycles (RD, CAP, WR).
- Pass of N>=1 words: 3N+1 cycles from first busy cycle to done, inclusive of the DONE cycle.
- len=0: busy for one cycle (DONE), done pulses the cycle after start.
- busy rises the cycle after the accepted start. busy falls the cycle after done.
- A new start is accepted in the cycle after DONE, i.e. back in IDLE.

## Configuration
- RELU_SEQ_STATS_EN defined:
  - neg_cnt port exists.
  - Cleared on accepted start.
  - In CAP, adds the number of lanes with bit 7 set (0..4).
  - Saturates at all-ones.
  - Holds its value after done until the next start; not cleared by abort.
- RELU_SEQ_STATS_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package cnn_pkg:
  - LANE_W=8, LANES=4, WORD_W=32
  - relu_seq_state_t enum {IDLE, RD, CAP, WR, DONE}
- Sub-module relu_lane4: a purely combinational 32-bit lane-wise clamp implementing the ReLU rule, instantiated once on the rd_data path feeding hold.

## Test plan
- Single word: src_base=0x10, len=1, mem[0x10]=0x80_7F_FF_01, wr_ready=1.
  - Expect one write of 0x00_7F_00_01 to dst_base; done at cycle 4 after busy rises; neg_cnt=2.
- Burst with wrap: src_base=0xFE, dst_base=0xFF, len=3.
  - Expect reads at 0xFE, 0xFF, 0x00 and writes at 0xFF, 0x00, 0x01, in order.
  - Expect 10 busy cycles.
- Back-pressure: len=2, wr_ready low for 5 cycles on the first WR.
  - Expect wr_en, wr_addr and wr_data stable throughout; no second rd_en until the write is accepted; done 5 cycles later than the unstalled case.
- Empty and ignored start: len=0 -> done the cycle after start, no rd_en or wr_en. A start pulsed mid-pass has no effect on addresses or count.
- Abort in WR of word 2 of 4: wr_en low the next cycle, IDLE, no done. A following start with len=1 completes normally.
- Async reset in CAP: rst_n low between clock edges -> all outputs zero immediately; after release, FSM is in IDLE and busy=0.
